spi_flash_reader: RTL
=====================

Name: spi_flash_reader

Overview:
- Wishbone master that sequences the SPI peripheral (data reg adr 0, status reg adr 1, speed reg adr 2) to perform serial-flash READ (opcode 0x03) bursts.
- Accepts a command (24-bit address, byte count).
- Drives chip select, pushes header and dummy bytes into the peripheral, and pops received bytes. Header echoes are discarded; payload is streamed out with valid/ready.
- Sits between the CPU-side boot/loader logic and the SPI peripheral, as its sole bus master.

Parameters:
- SPISPED, 5, value written to speed reg (adr 2, bits [15:0]) at start of every command.
- OPCODE, 8'h03, first byte sent.
- INFLIGHT, 6, max bytes sent but not yet popped (must be < 8, the receive FIFO depth).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  high only in IDLE
- cmd_addr_i  in  24  flash byte address
- cmd_len_i  in  8  payload bytes (0 = no-op)
- wb_adr_o  out  2  register select (adr[3:2])
- wb_sel_o  out  4  byte enables, always 4'b1111
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_ack_i  in  1  acknowledge (may be combinational, same cycle)
- spiCs_o  out  1  flash chip select, active low
- rd_data_o  out  8  payload byte
- rd_valid_o  out  1  payload valid
- rd_ready_i  in  1  payload accept
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at command end

Behaviour:
- Reset (async, rst_ni low): state IDLE, spiCs_o=1, wb_stb_o=0, wb_we_o=0, wb_adr_o=0, wb_dat_o=0, rd_valid_o=0, rd_data_o=0, done_o=0, busy_o=0, all counters 0. Reset mid-command aborts immediately; no completion pulse.
- Command handshake: command accepted when cmd_valid_i & cmd_ready_o. Address and length are latched, and total = len+4 (9-bit). cmd_valid_i is ignored while busy.
- len=0: go to DONE; done_o is high the next cycle; no bus activity; spiCs_o stays 1.
- Bus rule: in a bus state, stb is held until ack. The transfer completes on the ack cycle, read data is captured that cycle, and the state advances on the next edge. Never two consecutive strobed cycles to adr 0 with we=0 (each such cycle pops the FIFO).
- Status bits used: [0] recEmpty, [4] sendFull, [5] busy.
- Counters: sent, popped (9-bit). inflight = sent - popped.
- CFG: write adr 2, dat = SPISPED. Then go to CSLOW.
- CSLOW: spiCs_o <= 0 for one cycle. Then go to POLL.
- POLL: read adr 1. On ack, take the first matching branch:
  1. if !recEmpty, go to POP;
  2. else if sent<total & inflight<INFLIGHT & !sendFull, go to SEND;
  3. else if popped==total & !busy(status), go to CSHIGH;
  4. else stay in POLL (re-issue the read next cycle).
- SEND: write adr 0. Data is {24'b0, byte}, where byte = OPCODE, addr[23:16], addr[15:8], addr[7:0], then 0x00 for sent ≥ 4. sent++. Then go to POLL.
- POP: read adr 0, popped++. If the pre-increment popped is < 4, discard the byte and go to POLL. Otherwise rd_data_o = wb_dat_i[7:0] and go to OUT.
- OUT: rd_valid_o=1; rd_data_o is stable until rd_ready_i. After the handshake cycle, rd_valid_o=0 and go to POLL. No bus activity in OUT.
- CSHIGH: spiCs_o <= 1. Then go to DONE.
- DONE: done_o=1 for one cycle. Then go to IDLE.
- Ordering guarantees: payload bytes are emitted in address order. inflight never exceeds INFLIGHT, so the receive FIFO cannot overflow. spiCs_o rises only after the peripheral reports not-busy.

Test Plan:
- Reset, then cmd addr=0x123456 len=1 with a slave model that echoes MISO=0xA5 per byte:
  - bus writes: adr2=5, then adr0 = 0x03, 0x12, 0x34, 0x56, 0x00;
  - one rd_valid_o with 0xA5;
  - spiCs_o low throughout, high before done_o;
  - done_o pulses once.
- len=16, rd_ready_i low for 200 cycles after the first payload byte:
  - inflight ≤ 6 at every cycle;
  - no receive overflow;
  - 16 bytes out in order, matching model flash contents.
- len=0: done_o pulses 1 cycle after accept; zero wb_stb_o cycles; spiCs_o stays 1.
- cmd_valid_i held high while busy with different addr: second command not taken until cmd_ready_o returns; it then executes correctly.
- rst_ni pulsed low mid-burst (after 3 payload bytes):
  - immediately spiCs_o=1, stb=0, rd_valid_o=0, no done_o;
  - a following len=2 command runs cleanly.
- len=255 with rd_ready_i always 1: exactly 259 SEND writes and 259 POP reads; 255 payload bytes; no consecutive adr-0 read strobes.

Source files
------------

// File: rtl/spi_flash_reader.sv
// Wishbone master that drives the SPI peripheral to run serial-flash READ bursts.
// Header echoes are dropped; payload bytes stream out through a valid/ready port.
module spi_flash_reader #(
  parameter logic [15:0] SPISPED  = 16'd5,
  parameter logic [7:0]  OPCODE   = 8'h03,
  parameter int unsigned INFLIGHT = 6
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [23:0] cmd_addr_i,
  input  logic [7:0]  cmd_len_i,
  output logic [1:0]  wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        spiCs_o,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  input  logic        rd_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int unsigned CW  = 9;
  localparam int unsigned HDR = 4;

  localparam logic [1:0] ADR_DATA   = 2'd0;
  localparam logic [1:0] ADR_STATUS = 2'd1;
  localparam logic [1:0] ADR_SPEED  = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_CSLOW, S_POLL, S_SEND, S_POP, S_OUT, S_CSHIGH, S_DONE
  } state_t;

  state_t          state;
  logic [23:0]     addr_q;
  logic [CW-1:0]   total;
  logic [CW-1:0]   sent;
  logic [CW-1:0]   popped;
  logic [CW-1:0]   inflight;
  logic [7:0]      send_byte;
  logic            st_rec_empty;
  logic            st_send_full;
  logic            st_busy;
  logic            can_send;
  logic            unused_dat;

  assign wb_sel_o     = 4'b1111;
  assign inflight     = sent - popped;
  assign st_rec_empty = wb_dat_i[0];
  assign st_send_full = wb_dat_i[4];
  assign st_busy      = wb_dat_i[5];
  assign can_send     = (sent < total) && (inflight < CW'(INFLIGHT)) && !st_send_full;
  assign unused_dat   = ^wb_dat_i[31:8];

  // Opcode, three address bytes, then dummy bytes that clock the payload in.
  always_comb begin
    send_byte = 8'h00;
    case (sent)
      9'd0:    send_byte = OPCODE;
      9'd1:    send_byte = addr_q[23:16];
      9'd2:    send_byte = addr_q[15:8];
      9'd3:    send_byte = addr_q[7:0];
      default: send_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= S_IDLE;
      addr_q      <= 24'h0;
      total       <= '0;
      sent        <= '0;
      popped      <= '0;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      spiCs_o     <= 1'b1;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= 2'd0;
      wb_dat_o    <= 32'h0;
      rd_data_o   <= 8'h00;
      rd_valid_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            addr_q      <= cmd_addr_i;
            total       <= CW'(cmd_len_i) + CW'(HDR);
            sent        <= '0;
            popped      <= '0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            if (cmd_len_i == 8'd0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state    <= S_CFG;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b1;
              wb_adr_o <= ADR_SPEED;
              wb_dat_o <= {16'h0, SPISPED};
            end
          end
        end
        S_CFG: begin
          if (wb_ack_i) begin
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_dat_o <= 32'h0;
            spiCs_o  <= 1'b0;
            state    <= S_CSLOW;
          end
        end
        S_CSLOW: begin
          state    <= S_POLL;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b0;
          wb_adr_o <= ADR_STATUS;
        end
        // Status read; the strobe stays up while polling so each cycle re-issues it.
        S_POLL: begin
          if (wb_ack_i) begin
            if (!st_rec_empty) begin
              state    <= S_POP;
              wb_adr_o <= ADR_DATA;
            end else if (can_send) begin
              state    <= S_SEND;
              wb_we_o  <= 1'b1;
              wb_adr_o <= ADR_DATA;
              wb_dat_o <= {24'h0, send_byte};
            end else if ((popped == total) && !st_busy) begin
              state    <= S_CSHIGH;
              wb_stb_o <= 1'b0;
              spiCs_o  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (wb_ack_i) begin
            sent     <= sent + CW'(1);
            state    <= S_POLL;
            wb_we_o  <= 1'b0;
            wb_adr_o <= ADR_STATUS;
            wb_dat_o <= 32'h0;
          end
        end
        S_POP: begin
          if (wb_ack_i) begin
            popped <= popped + CW'(1);
            if (popped < CW'(HDR)) begin
              state    <= S_POLL;
              wb_adr_o <= ADR_STATUS;
            end else begin
              state      <= S_OUT;
              wb_stb_o   <= 1'b0;
              rd_data_o  <= wb_dat_i[7:0];
              rd_valid_o <= 1'b1;
            end
          end
        end
        S_OUT: begin
          if (rd_ready_i) begin
            rd_valid_o <= 1'b0;
            state      <= S_POLL;
            wb_stb_o   <= 1'b1;
            wb_adr_o   <= ADR_STATUS;
          end
        end
        S_CSHIGH: begin
          state  <= S_DONE;
          done_o <= 1'b1;
        end
        S_DONE: begin
          state       <= S_IDLE;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
